// File: rtl/report_pkg.sv
// Shared constants, state encoding and helpers for the ASCII counter reporter.
package report_pkg;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_I  = 8'h49;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_D  = 8'h44;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Nibble to uppercase ASCII hex digit ('A' is 0x37 + 10).
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/report_tick.sv
// Free-running period counter; tick is high for the cycle the count equals PERIOD-1.
module report_tick #(
  parameter int unsigned PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = $clog2(PERIOD);

  logic [CW-1:0] count;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = (count == CW'(PERIOD - 1)) ? '0 : count + CW'(1);
  end

  // tick is registered from the next count so it aligns with count == PERIOD-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count_d;
      tick  <= (count_d == CW'(PERIOD - 1));
    end
  end

endmodule

// File: rtl/report_frame.sv
// Snapshots N_CH counters plus mode flags and streams one checksummed ASCII
// line per trigger over a valid/require byte handshake.
module report_frame
  import report_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned REPORT_FREQ = 10,
  parameter int unsigned N_CH        = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  work,
  input  logic                  enc,
  input  logic [N_CH*CNT_W-1:0] cnt,
  input  logic                  snap_req,
  output logic [7:0]            data,
  output logic                  valid,
  input  logic                  require,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned PERIOD  = CLK_FREQ / REPORT_FREQ;
  localparam int unsigned HEX_D   = CNT_W / 4;
  localparam int unsigned CH_LEN  = HEX_D + 1;
  localparam int unsigned SEP_IDX = 2 + N_CH * CH_LEN;
  localparam int unsigned CKH_IDX = SEP_IDX + 1;
  localparam int unsigned CKL_IDX = SEP_IDX + 2;
  localparam int unsigned CR_IDX  = SEP_IDX + 3;
  localparam int unsigned LF_IDX  = SEP_IDX + 4;
  localparam int unsigned IDX_W   = $clog2(LF_IDX + 1);

  state_e                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [7:0]            chk, chk_d;
  logic                  pending, pending_d;
  logic [N_CH*CNT_W-1:0] snap_cnt, snap_cnt_d;
  logic                  snap_work, snap_work_d;
  logic                  snap_enc, snap_enc_d;
  logic                  overrun_d;
  logic [15:0]           frame_cnt_d;
  logic [7:0]            byte_d;
  logic [7:0]            data_d;
  logic                  valid_d;
  logic                  busy_d;
  logic                  tick;
  logic                  trig;
  logic                  xfer;

  report_tick #(.PERIOD(PERIOD)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Next-state, frame bookkeeping and trigger queuing.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    chk_d       = chk;
    pending_d   = pending;
    snap_cnt_d  = snap_cnt;
    snap_work_d = snap_work;
    snap_enc_d  = snap_enc;
    overrun_d   = overrun;
    frame_cnt_d = frame_cnt;
    trig        = tick | snap_req;
    xfer        = valid & require;
    case (state)
      ST_IDLE: begin
        if (trig || pending) begin
          state_d = ST_SNAP;
          if (trig && pending) overrun_d = 1'b1;
        end
      end
      ST_SNAP: begin
        snap_cnt_d  = cnt;
        snap_work_d = work;
        snap_enc_d  = enc;
        idx_d       = '0;
        chk_d       = '0;
        pending_d   = trig;
        state_d     = ST_EMIT;
      end
      ST_EMIT: begin
        if (trig) begin
          if (pending) overrun_d = 1'b1;
          else         pending_d = 1'b1;
        end
        if (xfer) begin
          if (idx < IDX_W'(CKH_IDX)) chk_d = chk ^ data;
          if (idx == IDX_W'(LF_IDX)) begin
            state_d     = ST_IDLE;
            frame_cnt_d = frame_cnt + 16'd1;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte selector, evaluated on next-cycle index/snapshot so data is registered.
  always_comb begin
    byte_d = ASCII_SP;
    if (idx_d == IDX_W'(0))            byte_d = snap_work_d ? ASCII_W : ASCII_I;
    else if (idx_d == IDX_W'(1))       byte_d = snap_enc_d ? ASCII_E : ASCII_D;
    else if (idx_d == IDX_W'(CKH_IDX)) byte_d = hex_char(chk_d[7:4]);
    else if (idx_d == IDX_W'(CKL_IDX)) byte_d = hex_char(chk_d[3:0]);
    else if (idx_d == IDX_W'(CR_IDX))  byte_d = ASCII_CR;
    else if (idx_d == IDX_W'(LF_IDX))  byte_d = ASCII_LF;
    for (int ch = 0; ch < int'(N_CH); ch++) begin
      for (int p = 1; p <= int'(HEX_D); p++) begin
        if (idx_d == IDX_W'(2 + ch * int'(CH_LEN) + p))
          byte_d = hex_char(snap_cnt_d[ch * int'(CNT_W) + (int'(HEX_D) - p) * 4 +: 4]);
      end
    end
  end

  always_comb begin
    valid_d = (state_d == ST_EMIT);
    busy_d  = (state_d != ST_IDLE);
    data_d  = valid_d ? byte_d : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      chk       <= '0;
      pending   <= 1'b0;
      snap_cnt  <= '0;
      snap_work <= 1'b0;
      snap_enc  <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      chk       <= chk_d;
      pending   <= pending_d;
      snap_cnt  <= snap_cnt_d;
      snap_work <= snap_work_d;
      snap_enc  <= snap_enc_d;
      overrun   <= overrun_d;
      frame_cnt <= frame_cnt_d;
      data      <= data_d;
      valid     <= valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_report_frame.sv
// Directed bench for report_frame: small 1-channel build, default build with no
// periodic ticks, and a PERIOD=100 build for periodic behaviour.
module tb_report_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, work, enc;
  logic        snap_a, snap_b, snap_c;
  logic        req_a, req_b, req_c;
  logic [7:0]  cnt_a;
  logic [63:0] cnt_b, cnt_c;
  logic [7:0]  data_a, data_b, data_c;
  logic        valid_a, valid_b, valid_c;
  logic        busy_a, busy_b, busy_c;
  logic        ovr_a, ovr_b, ovr_c;
  logic [15:0] fc_a, fc_b, fc_c;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        work;
    logic        enc;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [7:0]  ck;
  } vec_t;

  vec_t        vecs [4];
  logic [7:0]  exp_b [25];
  logic [7:0]  got_b [25];
  int          n_got;
  logic [127:0] hex_tab = "0123456789ABCDEF";

  report_frame #(.CLK_FREQ(1_000_000), .REPORT_FREQ(1), .N_CH(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .work(work), .enc(enc), .cnt(cnt_a), .snap_req(snap_a),
    .data(data_a), .valid(valid_a), .require(req_a), .busy(busy_a), .overrun(ovr_a),
    .frame_cnt(fc_a));

  report_frame #(.CLK_FREQ(50_000_000), .REPORT_FREQ(10), .N_CH(2), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .work(work), .enc(enc), .cnt(cnt_b), .snap_req(snap_b),
    .data(data_b), .valid(valid_b), .require(req_b), .busy(busy_b), .overrun(ovr_b),
    .frame_cnt(fc_b));

  report_frame #(.CLK_FREQ(1000), .REPORT_FREQ(10), .N_CH(2), .CNT_W(32)) u_c (
    .clk(clk), .rst_n(rst_n), .work(work), .enc(enc), .cnt(cnt_c), .snap_req(snap_c),
    .data(data_c), .valid(valid_c), .require(req_c), .busy(busy_c), .overrun(ovr_c),
    .frame_cnt(fc_c));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    hexc = hex_tab[(15 - int'(n)) * 8 +: 8];
  endfunction

  // Expected 25-byte frame; checksum digits come from the hand-computed table value.
  function automatic void build_exp(input vec_t v);
    logic [31:0] w;
    exp_b[0] = v.work ? "W" : "I";
    exp_b[1] = v.enc ? "E" : "D";
    for (int ch = 0; ch < 2; ch++) begin
      w = (ch == 0) ? v.c0 : v.c1;
      exp_b[2 + ch * 9] = " ";
      for (int d = 0; d < 8; d++) exp_b[3 + ch * 9 + d] = hexc(w[(7 - d) * 4 +: 4]);
    end
    exp_b[20] = " ";
    exp_b[21] = hexc(v.ck[7:4]);
    exp_b[22] = hexc(v.ck[3:0]);
    exp_b[23] = 8'h0D;
    exp_b[24] = 8'h0A;
  endfunction

  task automatic pulse_b();
    @(negedge clk); snap_b = 1'b1;
    @(negedge clk); snap_b = 1'b0;
  endtask

  // Collect one frame from u_b; optionally random require and mid-frame input changes.
  task automatic run_b(input bit rand_req, input bit mutate);
    logic [7:0] prev;
    bit         hold;
    int         cyc;
    n_got = 0; hold = 0; cyc = 0; prev = 8'h00;
    while (n_got < 25 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (hold) check("hold_stable", 64'(data_b), 64'(prev));
      req_b = rand_req ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mutate && n_got == 5) begin
        cnt_b = ~cnt_b; work = ~work; enc = ~enc;
      end
      if (valid_b && req_b) begin
        got_b[n_got] = data_b;
        n_got++;
        hold = 0;
      end else begin
        hold = valid_b;
        prev = data_b;
      end
    end
    check("frame_len", 64'(n_got), 64'd25);
    req_b = 1'b1;
  endtask

  task automatic cmp_frame(input string nm);
    for (int k = 0; k < 25; k++)
      check($sformatf("%s_byte%0d", nm, k), 64'(got_b[k]), 64'(exp_b[k]));
  endtask

  initial begin
    logic [7:0]  exp_a [10];
    logic [15:0] fc0;
    int          cyc, nr, k;
    int          rise [3];
    logic        pv;

    vecs[0] = '{1'b0, 1'b0, 32'h000000FF, 32'h1234ABCD, 8'h2D};
    vecs[1] = '{1'b1, 1'b1, 32'h00000000, 32'h00000000, 8'h32};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h33};
    vecs[3] = '{1'b0, 1'b1, 32'h00000001, 32'h80000000, 8'h25};
    exp_a = '{"W", "E", " ", "5", "A", " ", "6", "6", 8'h0D, 8'h0A};

    rst_n = 1'b0; work = 1'b0; enc = 1'b0;
    snap_a = 1'b0; snap_b = 1'b0; snap_c = 1'b0;
    req_a = 1'b1; req_b = 1'b1; req_c = 1'b1;
    cnt_a = 8'h00; cnt_b = '0; cnt_c = 64'h0000_0042_0000_0007;
    repeat (3) @(negedge clk);
    check("rst_data", 64'(data_b), 64'h0);
    check("rst_valid", 64'(valid_b), 64'h0);
    check("rst_busy", 64'(busy_a), 64'h0);
    check("rst_overrun", 64'(ovr_a), 64'h0);
    check("rst_fcnt", 64'(fc_a), 64'h0);
    rst_n = 1'b1;

    // Small build: "WE 5A 66\r\n" back to back.
    work = 1'b1; enc = 1'b1; cnt_a = 8'h5A;
    @(negedge clk); snap_a = 1'b1;
    @(negedge clk); snap_a = 1'b0;
    check("a_snap_busy", 64'(busy_a), 64'h1);
    check("a_snap_valid", 64'(valid_a), 64'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("a_valid%0d", i), 64'(valid_a), 64'h1);
      check($sformatf("a_byte%0d", i), 64'(data_a), 64'(exp_a[i]));
    end
    @(negedge clk);
    check("a_valid_end", 64'(valid_a), 64'h0);
    check("a_busy_end", 64'(busy_a), 64'h0);
    check("a_fcnt", 64'(fc_a), 64'h1);

    // Table of default-width frames with require held high.
    for (int i = 0; i < 4; i++) begin
      work = vecs[i].work; enc = vecs[i].enc; cnt_b = {vecs[i].c1, vecs[i].c0};
      build_exp(vecs[i]);
      fc0 = fc_b;
      pulse_b();
      run_b(1'b0, 1'b0);
      cmp_frame($sformatf("tbl%0d", i));
      @(negedge clk);
      check("tbl_fcnt", 64'(fc_b), 64'(fc0 + 16'd1));
      check("tbl_busy", 64'(busy_b), 64'h0);
    end

    // Random require with inputs changed mid-frame.
    work = vecs[0].work; enc = vecs[0].enc; cnt_b = {vecs[0].c1, vecs[0].c0};
    build_exp(vecs[0]);
    pulse_b();
    run_b(1'b1, 1'b1);
    cmp_frame("rnd");
    @(negedge clk);

    // Three requests during one frame: one extra frame, overrun set.
    work = vecs[1].work; enc = vecs[1].enc; cnt_b = {vecs[1].c1, vecs[1].c0};
    build_exp(vecs[1]);
    fc0 = fc_b;
    pulse_b();
    @(negedge clk);
    @(negedge clk); snap_b = 1'b1;
    @(negedge clk); snap_b = 1'b0;
    check("p3_ovr_first", 64'(ovr_b), 64'h0);
    @(negedge clk); snap_b = 1'b1;
    @(negedge clk); snap_b = 1'b0;
    @(negedge clk); snap_b = 1'b1;
    @(negedge clk); snap_b = 1'b0;
    check("p3_ovr_third", 64'(ovr_b), 64'h1);
    cyc = 0;
    while (valid_b && cyc < 50) begin @(negedge clk); cyc++; end
    check("p3_end_valid", 64'(valid_b), 64'h0);
    check("p3_idle_busy", 64'(busy_b), 64'h0);
    @(negedge clk);
    check("p3_snap_busy", 64'(busy_b), 64'h1);
    check("p3_snap_valid", 64'(valid_b), 64'h0);
    @(negedge clk);
    check("p3_next_valid", 64'(valid_b), 64'h1);
    check("p3_next_byte0", 64'(data_b), 64'(exp_b[0]));
    nr = 0; pv = 1'b1;
    repeat (60) begin @(negedge clk); if (valid_b && !pv) nr++; pv = valid_b; end
    check("p3_no_more", 64'(nr), 64'h0);
    check("p3_fcnt", 64'(fc_b), 64'(fc0 + 16'd2));
    check("p3_ovr_sticky", 64'(ovr_b), 64'h1);

    // Periodic build: frame start every 100 cycles.
    nr = 0; cyc = 0; pv = valid_c;
    while (nr < 3 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (valid_c && !pv) begin rise[nr] = cyc; nr++; end
      pv = valid_c;
    end
    check("c_rises", 64'(nr), 64'd3);
    check("c_period1", 64'(rise[1] - rise[0]), 64'd100);
    check("c_period2", 64'(rise[2] - rise[1]), 64'd100);
    check("c_busy", 64'(busy_c), 64'h1);
    check("c_byte0", 64'(data_c), work ? 64'h57 : 64'h49);
    // snap_req in the same cycle as the next tick counts once.
    repeat (97) @(negedge clk);
    @(negedge clk); snap_c = 1'b1;
    fc0 = fc_c;
    @(negedge clk); snap_c = 1'b0;
    nr = 0; pv = valid_c;
    repeat (100) begin @(negedge clk); if (valid_c && !pv) nr++; pv = valid_c; end
    check("c_coinc_frames", 64'(nr), 64'd1);
    check("c_coinc_fcnt", 64'(fc_c), 64'(fc0 + 16'd1));
    check("c_coinc_ovr", 64'(ovr_c), 64'h0);

    // Reset at byte 5 of a frame.
    work = vecs[2].work; enc = vecs[2].enc; cnt_b = {vecs[2].c1, vecs[2].c0};
    build_exp(vecs[2]);
    pulse_b();
    repeat (6) @(negedge clk);
    check("r_byte5", 64'(data_b), 64'(exp_b[5]));
    rst_n = 1'b0;
    #1;
    check("r_data", 64'(data_b), 64'h0);
    check("r_valid", 64'(valid_b), 64'h0);
    check("r_busy", 64'(busy_b), 64'h0);
    check("r_overrun", 64'(ovr_b), 64'h0);
    check("r_fcnt", 64'(fc_b), 64'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    repeat (30) begin @(negedge clk); if (valid_b) k++; end
    check("r_silent", 64'(k), 64'h0);
    pulse_b();
    run_b(1'b0, 1'b0);
    cmp_frame("r_frame");
    @(negedge clk);
    check("r_fcnt_after", 64'(fc_b), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
